seq_trigger_ctrl: RTL and testbench

Synthesizable sequence-trigger controller. It tracks two temporal patterns on sampled control signals: A = a ##1 b ##1 c, and D = d ##[MIN_DLY:MAX_DLY] e. It schedules overlapping D attempts across a fixed pool of tracker threads and queues timestamped match events to a downstream consumer over a valid/ready interface.

---
 rtl/seq_trigger_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seq_trigger_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_trigger_ctrl.sv
// rtl/seq_trigger_ctrl.sv - sequence trigger controller: A/D pattern tracking with timestamped event queue
module seq_trigger_ctrl #(
  parameter int MIN_DLY     = 2,
  parameter int MAX_DLY     = 5,
  parameter int NUM_THREADS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             abc_match,
  output logic             de_match,
  output logic             de_fail,
  output logic [CNT_W-1:0] abc_count,
  output logic [CNT_W-1:0] de_count,
  output logic             thread_ovf,
  output logic             rpt_ovf,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_id,
  output logic [TS_W-1:0]  evt_ts
);

  localparam int AGE_W = $clog2(MAX_DLY + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [AGE_W-1:0] MIN_AGE = AGE_W'(MIN_DLY);
  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_DLY);
  localparam logic [CW:0]      DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   a_h1_q, a_h1_d, a_h2_q, a_h2_d, b_h1_q, b_h1_d;
  logic [NUM_THREADS-1:0] busy_q, busy_d;
  logic [AGE_W-1:0]       age_q [NUM_THREADS];
  logic [AGE_W-1:0]       age_d [NUM_THREADS];
  logic                   abc_match_q, abc_match_d, de_match_q, de_match_d, de_fail_q, de_fail_d;
  logic [CNT_W-1:0]       abc_count_q, abc_count_d, de_count_q, de_count_d;
  logic                   thread_ovf_q, thread_ovf_d, rpt_ovf_q, rpt_ovf_d;
  logic                   id_mem_q [FIFO_DEPTH];
  logic                   id_mem_d [FIFO_DEPTH];
  logic [TS_W-1:0]        ts_mem_q [FIFO_DEPTH];
  logic [TS_W-1:0]        ts_mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic             abc_hit, de_hit, de_exp, d_drop, alloc_done;
  logic             pop, push_a, push_d;
  logic [CW:0]      free_slots;
  logic [PW-1:0]    wptr;
  logic [AGE_W-1:0] age_n;

  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    busy_d      = busy_q;
    age_d       = age_q;
    id_mem_d    = id_mem_q;
    ts_mem_d    = ts_mem_q;
    de_hit      = 1'b0;
    de_exp      = 1'b0;
    d_drop      = 1'b0;
    alloc_done  = 1'b0;
    age_n       = '0;

    abc_hit = en & a_h2_q & b_h1_q & c;
    a_h1_d  = en & a;
    a_h2_d  = en & a_h1_q;
    b_h1_d  = en & b;

    // Age first, then evaluate; a freed slot is visible to the allocator below.
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (busy_q[i]) begin
        age_n = age_q[i] + AGE_W'(1);
        if (!en) begin
          busy_d[i] = 1'b0;
          age_d[i]  = '0;
        end else if (e && age_n >= MIN_AGE && age_n <= MAX_AGE) begin
          de_hit    = 1'b1;
          busy_d[i] = 1'b0;
          age_d[i]  = '0;
        end else if (age_n == MAX_AGE) begin
          de_exp    = 1'b1;
          busy_d[i] = 1'b0;
          age_d[i]  = '0;
        end else begin
          age_d[i] = age_n;
        end
      end
    end

    if (en && d) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (!alloc_done && !busy_d[i]) begin
          busy_d[i]  = 1'b1;
          age_d[i]   = '0;
          alloc_done = 1'b1;
        end
      end
      d_drop = ~alloc_done;
    end

    abc_match_d = abc_hit;
    de_match_d  = de_hit;
    de_fail_d   = de_exp;

    abc_count_d = abc_count_q;
    de_count_d  = de_count_q;
    if (abc_hit && abc_count_q != {CNT_W{1'b1}}) abc_count_d = abc_count_q + CNT_W'(1);
    if (de_hit && de_count_q != {CNT_W{1'b1}})   de_count_d  = de_count_q + CNT_W'(1);

    // A pop at this edge frees its slot for a push at the same edge.
    pop        = (count_q != '0) && evt_ready;
    free_slots = DEPTH_W - {1'b0, count_q} + (CW + 1)'(pop);
    push_a     = abc_hit && (free_slots != '0);
    push_d     = de_hit && (free_slots > (CW + 1)'(push_a));

    wptr = wr_ptr_q;
    if (push_a) begin
      id_mem_d[wptr] = 1'b0;
      ts_mem_d[wptr] = ts_q;
      wptr           = wptr + PW'(1);
    end
    if (push_d) begin
      id_mem_d[wptr] = 1'b1;
      ts_mem_d[wptr] = ts_q;
      wptr           = wptr + PW'(1);
    end
    wr_ptr_d = wptr;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_a) + CW'(push_d) - CW'(pop);

    thread_ovf_d = clr ? 1'b0 : (thread_ovf_q | d_drop);
    rpt_ovf_d    = clr ? 1'b0 : (rpt_ovf_q | (abc_hit & ~push_a) | (de_hit & ~push_d));
    if (clr) begin
      abc_count_d = '0;
      de_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      a_h1_q       <= 1'b0;
      a_h2_q       <= 1'b0;
      b_h1_q       <= 1'b0;
      busy_q       <= '0;
      abc_match_q  <= 1'b0;
      de_match_q   <= 1'b0;
      de_fail_q    <= 1'b0;
      abc_count_q  <= '0;
      de_count_q   <= '0;
      thread_ovf_q <= 1'b0;
      rpt_ovf_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < NUM_THREADS; i++) age_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_mem_q[i] <= 1'b0;
        ts_mem_q[i] <= '0;
      end
    end else begin
      ts_q         <= ts_d;
      a_h1_q       <= a_h1_d;
      a_h2_q       <= a_h2_d;
      b_h1_q       <= b_h1_d;
      busy_q       <= busy_d;
      abc_match_q  <= abc_match_d;
      de_match_q   <= de_match_d;
      de_fail_q    <= de_fail_d;
      abc_count_q  <= abc_count_d;
      de_count_q   <= de_count_d;
      thread_ovf_q <= thread_ovf_d;
      rpt_ovf_q    <= rpt_ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      age_q        <= age_d;
      id_mem_q     <= id_mem_d;
      ts_mem_q     <= ts_mem_d;
    end
  end

  assign abc_match  = abc_match_q;
  assign de_match   = de_match_q;
  assign de_fail    = de_fail_q;
  assign abc_count  = abc_count_q;
  assign de_count   = de_count_q;
  assign thread_ovf = thread_ovf_q;
  assign rpt_ovf    = rpt_ovf_q;
  assign evt_valid  = (count_q != '0);
  assign evt_id     = id_mem_q[rd_ptr_q];
  assign evt_ts     = ts_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_seq_trigger_ctrl.sv
// tb/tb_seq_trigger_ctrl.sv - directed scenario bench for seq_trigger_ctrl
module tb_seq_trigger_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clr = 1'b0, evt_ready = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic        abc_match, de_match, de_fail, thread_ovf, rpt_ovf;
  logic        evt_valid, evt_id;
  logic [7:0]  abc_count, de_count;
  logic [15:0] evt_ts;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ev_n = 0;
  int n_fail = 0;
  int n_match = 0;
  logic        ev_id_log [256];
  logic [15:0] ev_ts_log [256];

  seq_trigger_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .abc_match(abc_match), .de_match(de_match), .de_fail(de_fail),
    .abc_count(abc_count), .de_count(de_count),
    .thread_ovf(thread_ovf), .rpt_ovf(rpt_ovf),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_ts(evt_ts)
  );

  always #5 clk = ~clk;

  // Record every accepted event and every pulse as the consumer would see them.
  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready && ev_n < 256) begin
      ev_id_log[ev_n] <= evt_id;
      ev_ts_log[ev_n] <= evt_ts;
      ev_n <= ev_n + 1;
    end
    if (de_fail) n_fail <= n_fail + 1;
    if (de_match) n_match <= n_match + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [4:0] v);
    {a, b, c, d, e} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic idle_to(input int k);
    drive(5'b00000);
    while (cyc < k) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    drive(5'b00000);
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (abc_match !== 1'b0) begin failures++; $display("FAIL reset_abc_match got=%0b exp=0", abc_match); end
    checks++; if (de_match !== 1'b0 || de_fail !== 1'b0) begin failures++; $display("FAIL reset_de_pulses got=%0b%0b exp=00", de_match, de_fail); end
    checks++; if (abc_count !== 8'd0 || de_count !== 8'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", abc_count, de_count); end
    checks++; if (thread_ovf !== 1'b0 || rpt_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b%0b exp=00", thread_ovf, rpt_ovf); end
    checks++; if (evt_valid !== 1'b0 || evt_id !== 1'b0 || evt_ts !== 16'd0) begin failures++; $display("FAIL reset_evt got=%0b/%0b/%0d exp=0/0/0", evt_valid, evt_id, evt_ts); end
  endtask

  task automatic test_basic_a();
    int ev0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    ev0 = ev_n;
    idle_to(2);
    drive(5'b10000); tick();
    drive(5'b01000); tick();
    checks++; if (abc_match !== 1'b0) begin failures++; $display("FAIL basic_early_match got=%0b exp=0", abc_match); end
    drive(5'b00100); tick();
    checks++; if (abc_match !== 1'b1) begin failures++; $display("FAIL basic_abc_match got=%0b exp=1", abc_match); end
    checks++; if (abc_count !== 8'd1) begin failures++; $display("FAIL basic_abc_count got=%0d exp=1", abc_count); end
    drive(5'b00000); tick(); tick();
    checks++; if (abc_match !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%0b exp=0", abc_match); end
    checks++; if (ev_n - ev0 !== 1) begin failures++; $display("FAIL basic_event_count got=%0d exp=1", ev_n - ev0); end
    else begin
      checks++; if (ev_id_log[ev0] !== 1'b0 || ev_ts_log[ev0] !== 16'd4) begin failures++; $display("FAIL basic_event got=%0b/%0d exp=0/4", ev_id_log[ev0], ev_ts_log[ev0]); end
    end
  endtask

  task automatic test_d_window();
    int ev0, f0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    ev0 = ev_n; f0 = n_fail;
    idle_to(10);
    drive(5'b00010); tick();
    drive(5'b00001); tick();
    checks++; if (de_match !== 1'b0) begin failures++; $display("FAIL dwin_too_early got=%0b exp=0", de_match); end
    drive(5'b00000); tick();
    drive(5'b00001); tick();
    checks++; if (de_match !== 1'b1 || de_count !== 8'd1) begin failures++; $display("FAIL dwin_match got=%0b/%0d exp=1/1", de_match, de_count); end
    drive(5'b00000); tick();
    checks++; if (de_match !== 1'b0) begin failures++; $display("FAIL dwin_pulse_width got=%0b exp=0", de_match); end
    idle_to(18);
    checks++; if (n_fail - f0 !== 0) begin failures++; $display("FAIL dwin_no_fail got=%0d exp=0", n_fail - f0); end
    checks++; if (ev_n - ev0 !== 1) begin failures++; $display("FAIL dwin_event_count got=%0d exp=1", ev_n - ev0); end
    else begin
      checks++; if (ev_id_log[ev0] !== 1'b1 || ev_ts_log[ev0] !== 16'd13) begin failures++; $display("FAIL dwin_event got=%0b/%0d exp=1/13", ev_id_log[ev0], ev_ts_log[ev0]); end
    end
  endtask

  task automatic test_d_expire();
    int ev0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    ev0 = ev_n;
    idle_to(10);
    drive(5'b00010); tick();
    idle_to(15);
    checks++; if (de_fail !== 1'b0) begin failures++; $display("FAIL dexp_early got=%0b exp=0", de_fail); end
    tick();
    checks++; if (de_fail !== 1'b1) begin failures++; $display("FAIL dexp_fail got=%0b exp=1", de_fail); end
    tick();
    checks++; if (de_fail !== 1'b0 || de_count !== 8'd0) begin failures++; $display("FAIL dexp_after got=%0b/%0d exp=0/0", de_fail, de_count); end
    checks++; if (ev_n - ev0 !== 0) begin failures++; $display("FAIL dexp_no_event got=%0d exp=0", ev_n - ev0); end
  endtask

  task automatic test_thread_ovf();
    logic exp_fail;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    idle_to(20);
    drive(5'b00010);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (thread_ovf !== 1'b0) begin failures++; $display("FAIL tovf_early got=%0b exp=0", thread_ovf); end
    tick();
    checks++; if (thread_ovf !== 1'b1) begin failures++; $display("FAIL tovf_set got=%0b exp=1", thread_ovf); end
    drive(5'b00000);
    for (int k = 25; k <= 29; k++) begin
      tick();
      exp_fail = (k <= 28);
      checks++; if (de_fail !== exp_fail) begin failures++; $display("FAIL tovf_fail_edge%0d got=%0b exp=%0b", k, de_fail, exp_fail); end
    end
    checks++; if (thread_ovf !== 1'b1) begin failures++; $display("FAIL tovf_sticky got=%0b exp=1", thread_ovf); end
  endtask

  task automatic test_simultaneous();
    int ev0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    ev0 = ev_n;
    idle_to(29);
    drive(5'b00010); tick();
    drive(5'b10000); tick();
    drive(5'b01000); tick();
    drive(5'b00101); tick();
    checks++; if (abc_match !== 1'b1 || de_match !== 1'b1) begin failures++; $display("FAIL sim_pulses got=%0b%0b exp=11", abc_match, de_match); end
    drive(5'b00000); tick(); tick(); tick();
    checks++; if (ev_n - ev0 !== 2) begin failures++; $display("FAIL sim_event_count got=%0d exp=2", ev_n - ev0); end
    else begin
      checks++; if (ev_id_log[ev0] !== 1'b0 || ev_ts_log[ev0] !== 16'd32) begin failures++; $display("FAIL sim_first got=%0b/%0d exp=0/32", ev_id_log[ev0], ev_ts_log[ev0]); end
      checks++; if (ev_id_log[ev0+1] !== 1'b1 || ev_ts_log[ev0+1] !== 16'd32) begin failures++; $display("FAIL sim_second got=%0b/%0d exp=1/32", ev_id_log[ev0+1], ev_ts_log[ev0+1]); end
    end
  endtask

  task automatic test_enable();
    int f0, m0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    f0 = n_fail; m0 = n_match;
    idle_to(2);
    drive(5'b00010); tick();
    drive(5'b10000); tick();
    drive(5'b01000); en = 1'b0; tick();
    en = 1'b1;
    drive(5'b00100); tick();
    drive(5'b00001); tick();
    idle_to(12);
    checks++; if (n_match - m0 !== 0 || de_count !== 8'd0) begin failures++; $display("FAIL en_no_de got=%0d/%0d exp=0/0", n_match - m0, de_count); end
    checks++; if (n_fail - f0 !== 0) begin failures++; $display("FAIL en_no_fail got=%0d exp=0", n_fail - f0); end
    checks++; if (abc_count !== 8'd0) begin failures++; $display("FAIL en_no_abc got=%0d exp=0", abc_count); end
  endtask

  task automatic test_backpressure();
    int ev0;
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    drive(5'b11100);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k >= 2) begin
        checks++; if (evt_valid !== 1'b1 || evt_id !== 1'b0 || evt_ts !== 16'd2) begin failures++; $display("FAIL bp_head_edge%0d got=%0b/%0b/%0d exp=1/0/2", k, evt_valid, evt_id, evt_ts); end
      end
      if (k == 5) begin
        checks++; if (rpt_ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_early got=%0b exp=0", rpt_ovf); end
      end
    end
    checks++; if (rpt_ovf !== 1'b1 || abc_count !== 8'd5) begin failures++; $display("FAIL bp_ovf got=%0b/%0d exp=1/5", rpt_ovf, abc_count); end
    drive(5'b00000); clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (rpt_ovf !== 1'b0 || abc_count !== 8'd0) begin failures++; $display("FAIL bp_clr got=%0b/%0d exp=0/0", rpt_ovf, abc_count); end
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'd2) begin failures++; $display("FAIL bp_clr_queue got=%0b/%0d exp=1/2", evt_valid, evt_ts); end
    ev0 = ev_n;
    evt_ready = 1'b1;
    for (int i = 0; i < 8 && evt_valid; i++) tick();
    checks++; if (evt_valid !== 1'b0 || ev_n - ev0 !== 4) begin failures++; $display("FAIL bp_drain got=%0b/%0d exp=0/4", evt_valid, ev_n - ev0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (ev_id_log[ev0+i] !== 1'b0 || ev_ts_log[ev0+i] !== 16'(2 + i)) begin failures++; $display("FAIL bp_entry%0d got=%0b/%0d exp=0/%0d", i, ev_id_log[ev0+i], ev_ts_log[ev0+i], 2 + i); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ev0, f0, m0;
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    idle_to(40);
    drive(5'b00010); tick();
    drive(5'b00000); tick();
    ev0 = ev_n; f0 = n_fail; m0 = n_match;
    rst = 1'b1; tick(); rst = 1'b0; cyc = 0;
    checks++; if (de_fail !== 1'b0 || de_match !== 1'b0 || de_count !== 8'd0) begin failures++; $display("FAIL rmid_outputs got=%0b/%0b/%0d exp=0/0/0", de_fail, de_match, de_count); end
    checks++; if (evt_valid !== 1'b0 || evt_ts !== 16'd0) begin failures++; $display("FAIL rmid_evt got=%0b/%0d exp=0/0", evt_valid, evt_ts); end
    tick();
    drive(5'b00001); tick();
    drive(5'b00000);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (n_match - m0 !== 0 || n_fail - f0 !== 0) begin failures++; $display("FAIL rmid_pulses got=%0d/%0d exp=0/0", n_match - m0, n_fail - f0); end
    checks++; if (ev_n - ev0 !== 0) begin failures++; $display("FAIL rmid_events got=%0d exp=0", ev_n - ev0); end
  endtask

  initial begin
    test_reset();
    test_basic_a();
    test_d_window();
    test_d_expire();
    test_thread_ovf();
    test_simultaneous();
    test_enable();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
